// File: rtl/cabac_ctx_pkg.sv
// ---------------------------------------------------------------------------
// cabac_ctx_pkg
// Shared definitions for the CABAC context-model manager:
//   - context geometry (count, index width, word width)
//   - context word layout {pStateIdx[5:0], valMps}
//   - LPS state transition table
//   - manager FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package cabac_ctx_pkg;

  localparam int CTX_NUM = 64;
  localparam int CTX_AW  = 6;
  localparam int CTX_W   = 7;
  localparam int PS_W    = 6;

  // Word field offsets: valMps in bit 0, pStateIdx in bits 6:1.
  localparam int MPS_BIT = 0;
  localparam int PS_LSB  = 1;
  localparam int PS_MSB  = 6;

  localparam logic [CTX_AW-1:0] CNT_LAST   = CTX_AW'(CTX_NUM - 1);
  localparam logic [PS_W-1:0]   PS_MPS_MAX = 6'd62;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } ctx_state_e;

  localparam logic [PS_W-1:0] TRANS_IDX_LPS [CTX_NUM] = '{
    6'd0,  6'd0,  6'd1,  6'd2,  6'd2,  6'd4,  6'd4,  6'd5,
    6'd6,  6'd7,  6'd8,  6'd9,  6'd9,  6'd11, 6'd11, 6'd12,
    6'd13, 6'd13, 6'd15, 6'd15, 6'd16, 6'd16, 6'd18, 6'd18,
    6'd19, 6'd19, 6'd21, 6'd21, 6'd22, 6'd22, 6'd23, 6'd24,
    6'd24, 6'd25, 6'd26, 6'd26, 6'd27, 6'd27, 6'd28, 6'd29,
    6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33,
    6'd33, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd35, 6'd36,
    6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd63
  };

  function automatic logic [PS_W-1:0] trans_idx_lps(input logic [PS_W-1:0] ps);
    return TRANS_IDX_LPS[ps];
  endfunction

  function automatic logic [CTX_W-1:0] ctx_word(input logic [PS_W-1:0] ps,
                                                input logic            mps);
    return {ps, mps};
  endfunction

endpackage

// File: rtl/cabac_ctx_init_calc.sv
// ---------------------------------------------------------------------------
// cabac_ctx_init_calc
// Combinational derivation of one initial context word from its 8-bit init
// value and the slice QP.
// Ports:
//   init_val_i  in  8  {slope[3:0], offset[3:0]}
//   qp_i        in  6  slice QP (clipped to 0..51 internally)
//   word_o      out 7  {pStateIdx[5:0], valMps}
// ---------------------------------------------------------------------------
module cabac_ctx_init_calc
  import cabac_ctx_pkg::*;
(
  input  logic [7:0]       init_val_i,
  input  logic [5:0]       qp_i,
  output logic [CTX_W-1:0] word_o
);

  logic [3:0]         slope;
  logic [3:0]         offset;
  logic [6:0]         slope_x5;
  logic signed [7:0]  m;
  logic signed [7:0]  n;
  logic [5:0]         qp_c;
  logic signed [12:0] m_ext;
  logic signed [12:0] qp_ext;
  logic signed [12:0] prod;
  logic signed [12:0] prod_sh;
  logic signed [13:0] pre_raw;
  logic [6:0]         pre;
  logic               mps;
  logic [PS_W-1:0]    ps;

  // Product fits 13-bit signed (|m| <= 45, qp <= 51); the >>> 4 must floor,
  // so everything on that path stays signed.
  always_comb begin
    slope    = init_val_i[7:4];
    offset   = init_val_i[3:0];
    slope_x5 = {1'b0, slope, 2'b00} + {3'b000, slope};
    m        = $signed({1'b0, slope_x5}) - 8'sd45;
    n        = $signed({1'b0, offset, 3'b000}) - 8'sd16;
    qp_c     = (qp_i > 6'd51) ? 6'd51 : qp_i;
    m_ext    = {{5{m[7]}}, m};
    qp_ext   = {7'b0000000, qp_c};
    prod     = m_ext * qp_ext;
    prod_sh  = prod >>> 4;
    pre_raw  = {prod_sh[12], prod_sh} + {{6{n[7]}}, n};
    if (pre_raw < 14'sd1) begin
      pre = 7'd1;
    end else if (pre_raw > 14'sd126) begin
      pre = 7'd126;
    end else begin
      pre = pre_raw[6:0];
    end
    // pre is 1..126: above 63 the low six bits are already pre-64.
    mps    = pre[6];
    ps     = mps ? pre[5:0] : (6'd63 - pre[5:0]);
    word_o = ctx_word(ps, mps);
  end

endmodule

// File: rtl/cabac_ctx_mgr.sv
// ---------------------------------------------------------------------------
// cabac_ctx_mgr
// Controller for the 64-entry CABAC context register file. On start_i it
// writes all 64 initial contexts (one per cycle), then serves per-bin
// lookups with a two-stage read / update-and-write-back pipeline.
// Optional statistics counters are built when CABAC_CTX_STAT_EN is defined.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start_i, qp_i           begin initialisation with this slice QP
//   init_addr_o, init_val_i init-table lookup (combinational return)
//   init_done_o             one-cycle pulse at end of initialisation
//   ctx_rdy_o               lookups accepted
//   ctx_req_i, ctx_idx_i, bin_i   lookup request
//   ctx_vld_o, ctx_pstate_o, ctx_mps_o   state before update
//   rf_r_*                  RF read port (data one cycle after enable)
//   rf_w_*                  RF write port
//   bin_cnt_o, lps_cnt_o    (CABAC_CTX_STAT_EN only) saturating counters
// ---------------------------------------------------------------------------
module cabac_ctx_mgr
  import cabac_ctx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [5:0]        qp_i,
  output logic [CTX_AW-1:0] init_addr_o,
  input  logic [7:0]        init_val_i,
  output logic              init_done_o,
  output logic              ctx_rdy_o,
  input  logic              ctx_req_i,
  input  logic [CTX_AW-1:0] ctx_idx_i,
  input  logic              bin_i,
  output logic              ctx_vld_o,
  output logic [PS_W-1:0]   ctx_pstate_o,
  output logic              ctx_mps_o,
`ifdef CABAC_CTX_STAT_EN
  output logic [15:0]       bin_cnt_o,
  output logic [15:0]       lps_cnt_o,
`endif
  output logic              rf_r_en_o,
  output logic [CTX_AW-1:0] rf_r_addr_o,
  input  logic [CTX_W-1:0]  rf_r_data_i,
  output logic              rf_w_en_o,
  output logic [CTX_AW-1:0] rf_w_addr_o,
  output logic [CTX_W-1:0]  rf_w_data_o
);

  ctx_state_e        state_q, state_d;
  logic [CTX_AW-1:0] cnt_q, cnt_d;
  logic [5:0]        qp_q, qp_d;
  logic              done_q, done_d;

  logic              s1_vld_q, s1_vld_d;
  logic [CTX_AW-1:0] s1_idx_q, s1_idx_d;
  logic              s1_bin_q, s1_bin_d;
  logic              byp_q, byp_d;
  logic [CTX_W-1:0]  fwd_q, fwd_d;

  logic              init_active;
  logic              rdy;
  logic              accept;
  logic [CTX_W-1:0]  init_word;
  logic [CTX_W-1:0]  cur_word;
  logic [PS_W-1:0]   cur_ps;
  logic              cur_mps;
  logic              is_lps;
  logic [PS_W-1:0]   upd_ps;
  logic              upd_mps;
  logic [CTX_W-1:0]  upd_word;

  cabac_ctx_init_calc u_init_calc (
    .init_val_i (init_val_i),
    .qp_i       (qp_q),
    .word_o     (init_word)
  );

  // start_i wins from any state and restarts the sweep at index 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qp_d    = qp_q;
    done_d  = 1'b0;
    if (start_i) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      qp_d    = qp_i;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      qp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qp_q    <= qp_d;
      done_q  <= done_d;
    end
  end

  // Readiness drops combinationally with start_i so no lookup slips in
  // alongside a restart.
  assign init_active = (state_q == ST_INIT);
  assign rdy         = (state_q == ST_READY) && !start_i;
  assign accept      = ctx_req_i && rdy;

  // S1 state source: the RF returns the pre-write value when S0 reads the
  // same index S1 is writing, so that case takes the forwarded word.
  always_comb begin
    cur_word = byp_q ? fwd_q : rf_r_data_i;
    cur_ps   = cur_word[PS_MSB:PS_LSB];
    cur_mps  = cur_word[MPS_BIT];
    is_lps   = (s1_bin_q != cur_mps);
    upd_mps  = cur_mps;
    if (!is_lps) begin
      upd_ps = (cur_ps >= PS_MPS_MAX) ? PS_MPS_MAX : (cur_ps + 6'd1);
    end else begin
      if (cur_ps == '0) begin
        upd_mps = ~cur_mps;
      end
      upd_ps = trans_idx_lps(cur_ps);
    end
    upd_word = ctx_word(upd_ps, upd_mps);
  end

  always_comb begin
    s1_vld_d = accept;
    s1_idx_d = accept ? ctx_idx_i : s1_idx_q;
    s1_bin_d = accept ? bin_i : s1_bin_q;
    byp_d    = accept && s1_vld_q && (ctx_idx_i == s1_idx_q);
    fwd_d    = upd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s1_bin_q <= 1'b0;
      byp_q    <= 1'b0;
      fwd_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_idx_q <= s1_idx_d;
      s1_bin_q <= s1_bin_d;
      byp_q    <= byp_d;
      fwd_q    <= fwd_d;
    end
  end

  // INIT and S1 never overlap: the first INIT cycle always follows a
  // start_i cycle, in which no lookup is accepted.
  always_comb begin
    init_addr_o  = init_active ? cnt_q : '0;
    init_done_o  = done_q;
    ctx_rdy_o    = rdy;
    rf_r_en_o    = accept;
    rf_r_addr_o  = accept ? ctx_idx_i : '0;
    ctx_vld_o    = s1_vld_q;
    ctx_pstate_o = s1_vld_q ? cur_ps : '0;
    ctx_mps_o    = s1_vld_q ? cur_mps : 1'b0;
    rf_w_en_o    = 1'b0;
    rf_w_addr_o  = '0;
    rf_w_data_o  = '0;
    if (init_active) begin
      rf_w_en_o   = 1'b1;
      rf_w_addr_o = cnt_q;
      rf_w_data_o = init_word;
    end else if (s1_vld_q) begin
      rf_w_en_o   = 1'b1;
      rf_w_addr_o = s1_idx_q;
      rf_w_data_o = upd_word;
    end
  end

`ifdef CABAC_CTX_STAT_EN
  logic [15:0] bin_cnt_q, bin_cnt_d;
  logic [15:0] lps_cnt_q, lps_cnt_d;

  // Counters saturate at all-ones; a restart clears them even if an S1
  // update lands in the same cycle.
  always_comb begin
    bin_cnt_d = bin_cnt_q;
    lps_cnt_d = lps_cnt_q;
    if (start_i) begin
      bin_cnt_d = '0;
      lps_cnt_d = '0;
    end else if (s1_vld_q) begin
      if (bin_cnt_q != 16'hFFFF) begin
        bin_cnt_d = bin_cnt_q + 16'd1;
      end
      if (is_lps && (lps_cnt_q != 16'hFFFF)) begin
        lps_cnt_d = lps_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_q <= '0;
      lps_cnt_q <= '0;
    end else begin
      bin_cnt_q <= bin_cnt_d;
      lps_cnt_q <= lps_cnt_d;
    end
  end

  assign bin_cnt_o = bin_cnt_q;
  assign lps_cnt_o = lps_cnt_q;
`endif

endmodule

// File: tb/tb_cabac_ctx_mgr.sv
// ---------------------------------------------------------------------------
// tb_cabac_ctx_mgr
// Bench for cabac_ctx_mgr with a behavioural register file, an init-value
// table, and a context reference model. Expected init writes, lookup
// results and init-done cycles are queued by the driver and consumed by a
// negedge monitor.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cabac_ctx_mgr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [5:0] qp_i = '0;
  logic [5:0] init_addr_o;
  logic [7:0] init_val_i;
  logic       init_done_o;
  logic       ctx_rdy_o;
  logic       ctx_req_i = 1'b0;
  logic [5:0] ctx_idx_i = '0;
  logic       bin_i = 1'b0;
  logic       ctx_vld_o;
  logic [5:0] ctx_pstate_o;
  logic       ctx_mps_o;
  logic       rf_r_en_o;
  logic [5:0] rf_r_addr_o;
  logic [6:0] rf_r_data_i = '0;
  logic       rf_w_en_o;
  logic [5:0] rf_w_addr_o;
  logic [6:0] rf_w_data_o;

  cabac_ctx_mgr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .qp_i         (qp_i),
    .init_addr_o  (init_addr_o),
    .init_val_i   (init_val_i),
    .init_done_o  (init_done_o),
    .ctx_rdy_o    (ctx_rdy_o),
    .ctx_req_i    (ctx_req_i),
    .ctx_idx_i    (ctx_idx_i),
    .bin_i        (bin_i),
    .ctx_vld_o    (ctx_vld_o),
    .ctx_pstate_o (ctx_pstate_o),
    .ctx_mps_o    (ctx_mps_o),
    .rf_r_en_o    (rf_r_en_o),
    .rf_r_addr_o  (rf_r_addr_o),
    .rf_r_data_i  (rf_r_data_i),
    .rf_w_en_o    (rf_w_en_o),
    .rf_w_addr_o  (rf_w_addr_o),
    .rf_w_data_o  (rf_w_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: synchronous read returning the pre-write value.
  logic [6:0] rf_mem [64];
  always @(posedge clk) begin
    if (rf_r_en_o) rf_r_data_i <= rf_mem[rf_r_addr_o];
    if (rf_w_en_o) rf_mem[rf_w_addr_o] <= rf_w_data_o;
  end

  logic [7:0] init_tab [64];
  assign init_val_i = init_tab[init_addr_o];

  int lps_tab [64] = '{
    0, 0, 1, 2, 2, 4, 4, 5, 6, 7, 8, 9, 9, 11, 11, 12,
    13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
    24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
    33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63
  };

  typedef struct { int ps; int mps; int idx; int wdata; } out_exp_t;
  typedef struct { int addr; int data; } init_exp_t;

  out_exp_t  exp_out_q [$];
  init_exp_t exp_init_q [$];
  int        exp_done_q [$];

  int ref_ps [64];
  int ref_mps [64];
  int fixed_word [64];

  int checks = 0;
  int failures = 0;
  bit in_init = 0;
  int init_wr_cnt = 0;
  int init_rd_cnt = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Initial word straight from the arithmetic rules, floor division by 16.
  function automatic int refInit(input int v, input int qp);
    int slope = v / 16;
    int off   = v % 16;
    int m     = slope * 5 - 45;
    int n     = off * 8 - 16;
    int q     = (qp > 51) ? 51 : qp;
    int prod  = m * q;
    int sh    = (prod >= 0) ? (prod / 16) : -((-prod + 15) / 16);
    int pre   = sh + n;
    int mps;
    int ps;
    if (pre < 1) pre = 1;
    if (pre > 126) pre = 126;
    mps = (pre > 63) ? 1 : 0;
    ps  = mps ? (pre - 64) : (63 - pre);
    return ps * 2 + mps;
  endfunction

  task automatic applyStart(input int qp);
    init_exp_t ie;
    int w;
    @(posedge clk); #2;
    ctx_req_i = 1'b0;
    start_i   = 1'b1;
    qp_i      = qp[5:0];
    for (int i = 0; i < 64; i++) begin
      w = (fixed_word[i] >= 0) ? fixed_word[i] : refInit(int'(init_tab[i]), qp);
      ref_ps[i]  = w / 2;
      ref_mps[i] = w % 2;
      ie.addr = i;
      ie.data = w;
      exp_init_q.push_back(ie);
    end
    exp_done_q.push_back(cyc + 65);
    in_init = 1;
    #1;
    checkOutput("rdy_drop_on_start", int'(ctx_rdy_o), 0);
    @(posedge clk); #2;
    start_i = 1'b0;
    qp_i    = 6'($urandom);
  endtask

  // Requests are thrown at the DUT while it initialises; they must be ignored.
  task automatic waitDone();
    bit seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (init_done_o) begin
        seen = 1;
        break;
      end
      ctx_req_i = 1'($urandom);
      ctx_idx_i = 6'($urandom);
      bin_i     = 1'($urandom);
    end
    ctx_req_i = 1'b0;
    checkOutput("init_done_seen", int'(seen), 1);
  endtask

  task automatic applyStimulus(input int idx, input int bin);
    out_exp_t e;
    @(posedge clk); #2;
    ctx_req_i = 1'b1;
    ctx_idx_i = idx[5:0];
    bin_i     = bin[0];
    e.ps  = ref_ps[idx];
    e.mps = ref_mps[idx];
    e.idx = idx;
    if (bin == ref_mps[idx]) begin
      ref_ps[idx] = (ref_ps[idx] + 1 > 62) ? 62 : ref_ps[idx] + 1;
    end else begin
      if (ref_ps[idx] == 0) ref_mps[idx] = 1 - ref_mps[idx];
      ref_ps[idx] = lps_tab[ref_ps[idx]];
    end
    e.wdata = ref_ps[idx] * 2 + ref_mps[idx];
    exp_out_q.push_back(e);
  endtask

  task automatic idleCycle();
    @(posedge clk); #2;
    ctx_req_i = 1'b0;
    ctx_idx_i = 6'($urandom);
    bin_i     = 1'($urandom);
  endtask

  task automatic randomPhase(input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
        applyStimulus(idx, int'($urandom_range(0, 1)));
      end else begin
        idleCycle();
      end
    end
    idleCycle();
  endtask

  // Monitor: consumes queued expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_init && rf_r_en_o) init_rd_cnt++;
      if (ctx_vld_o) begin
        if (exp_out_q.size() == 0) begin
          checkOutput("unexpected_ctx_vld", 1, 0);
        end else begin
          out_exp_t e;
          e = exp_out_q.pop_front();
          checkOutput("ctx_pstate", int'(ctx_pstate_o), e.ps);
          checkOutput("ctx_mps", int'(ctx_mps_o), e.mps);
          checkOutput("s1_w_en", int'(rf_w_en_o), 1);
          checkOutput("s1_w_addr", int'(rf_w_addr_o), e.idx);
          checkOutput("s1_w_data", int'(rf_w_data_o), e.wdata);
        end
      end else if (rf_w_en_o) begin
        init_wr_cnt++;
        if (exp_init_q.size() == 0) begin
          checkOutput("unexpected_rf_write", 1, 0);
        end else begin
          init_exp_t ie;
          ie = exp_init_q.pop_front();
          checkOutput("init_w_addr", int'(rf_w_addr_o), ie.addr);
          checkOutput("init_addr_o", int'(init_addr_o), ie.addr);
          checkOutput("init_w_data", int'(rf_w_data_o), ie.data);
        end
      end
      if (init_done_o) begin
        if (exp_done_q.size() == 0) begin
          checkOutput("unexpected_init_done", 1, 0);
        end else begin
          checkOutput("init_done_cycle", cyc, exp_done_q.pop_front());
        end
        checkOutput("rdy_at_done", int'(ctx_rdy_o), 1);
        checkOutput("init_write_count", init_wr_cnt, 64);
        checkOutput("reads_during_init", init_rd_cnt, 0);
        init_wr_cnt = 0;
        init_rd_cnt = 0;
        in_init = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      rf_mem[i]     = '0;
      init_tab[i]   = '0;
      fixed_word[i] = -1;
    end

    // Reset: outputs quiet even with a request pending.
    ctx_req_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ctx_rdy", int'(ctx_rdy_o), 0);
    checkOutput("rst_ctx_vld", int'(ctx_vld_o), 0);
    checkOutput("rst_init_done", int'(init_done_o), 0);
    checkOutput("rst_rf_r_en", int'(rf_r_en_o), 0);
    checkOutput("rst_rf_w_en", int'(rf_w_en_o), 0);
    checkOutput("rst_init_addr", int'(init_addr_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ctx_rdy", int'(ctx_rdy_o), 0);
    checkOutput("idle_rf_r_en", int'(rf_r_en_o), 0);
    ctx_req_i = 1'b0;

    // Slice 1, QP 26: known words at ctx 0 {0,1}, ctx 1 {0,0}, ctx 2 {62,1}.
    for (int i = 0; i < 64; i++) init_tab[i] = 8'($urandom);
    init_tab[0] = 8'd154;
    init_tab[1] = 8'd139;
    init_tab[2] = 8'd255;
    fixed_word[0] = 1;
    fixed_word[1] = 0;
    fixed_word[2] = 125;
    applyStart(26);
    waitDone();
    for (int i = 0; i < 64; i++) fixed_word[i] = -1;

    applyStimulus(0, 1);
    applyStimulus(0, 0);
    idleCycle();
    applyStimulus(0, 0);
    idleCycle();
    applyStimulus(1, 1);
    idleCycle();
    applyStimulus(2, 1);
    applyStimulus(2, 1);
    idleCycle();
    applyStimulus(2, 1);
    idleCycle();
    randomPhase(150);

    // Slice 2, QP 2, restarted while an S1 update is in flight; ctx 5 = {10,0}.
    for (int i = 0; i < 64; i++) init_tab[i] = 8'($urandom);
    init_tab[5] = 8'h59;
    fixed_word[5] = 20;
    applyStimulus(int'($urandom_range(0, 63)), int'($urandom_range(0, 1)));
    applyStart(2);
    waitDone();
    applyStimulus(5, 0);
    applyStimulus(5, 0);
    applyStimulus(5, 0);
    idleCycle();
    applyStimulus(5, 0);
    idleCycle();

    // Slice 3: same contexts, same MPS sequence with one-cycle gaps.
    applyStart(2);
    waitDone();
    for (int i = 0; i < 64; i++) fixed_word[i] = -1;
    applyStimulus(5, 0);
    idleCycle();
    applyStimulus(5, 0);
    idleCycle();
    applyStimulus(5, 0);
    idleCycle();
    applyStimulus(5, 0);
    idleCycle();
    randomPhase(150);

    repeat (4) @(posedge clk);
    #2;
    checkOutput("out_queue_drained", exp_out_q.size(), 0);
    checkOutput("init_queue_drained", exp_init_q.size(), 0);
    checkOutput("done_queue_drained", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cabac_ctx_mgr.md
Name: cabac_ctx_mgr

Overview:
- Context-model manager on the controller side of the 7x64 CABAC context register file.
- At slice start it computes the 64 initial context states from the init values and the slice QP, and writes them into the RF.
- It then serves per-bin context lookups from the binary arithmetic coder:
  - reads the context state;
  - presents the state to the coder;
  - writes back the updated state.
- Word format: {pStateIdx[5:0], valMps}.

Parameters:
- CTX_NUM, 64, number of contexts; equals RF depth.
- CTX_AW, 6, context index width.
- CTX_W, 7, context word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start_i  in  1  pulse; begin context initialisation.
- qp_i  in  6  slice QP; sampled on start_i.
- init_addr_o  out  6  init-table index.
- init_val_i  in  8  init value for init_addr_o; combinational, same cycle.
- init_done_o  out  1  one-cycle pulse when initialisation completes.
- ctx_rdy_o  out  1  high when lookups are accepted.
- ctx_req_i  in  1  lookup request.
- ctx_idx_i  in  6  context index.
- bin_i  in  1  bin value coded with this context.
- ctx_vld_o  out  1  state output valid.
- ctx_pstate_o  out  6  pStateIdx before update.
- ctx_mps_o  out  1  valMps before update.
- rf_r_en_o  out  1  RF read enable.
- rf_r_addr_o  out  6  RF read address.
- rf_r_data_i  in  7  RF read data, one cycle after rf_r_en_o.
- rf_w_en_o  out  1  RF write enable.
- rf_w_addr_o  out  6  RF write address.
- rf_w_data_o  out  7  RF write data.

Behaviour:
- Reset: FSM=IDLE; all outputs 0; ctx_rdy_o=0.
- FSM states and transitions:
  - IDLE -> INIT on start_i.
  - INIT runs 64 cycles, cnt 0..63, then -> READY with init_done_o=1 for one cycle.
  - READY -> INIT on start_i.
  - start_i during INIT restarts cnt at 0 with the new qp_i.
- INIT, per cycle:
  - Outputs: init_addr_o=cnt; rf_w_en_o=1; rf_w_addr_o=cnt.
  - slope=init_val_i[7:4]; offset=init_val_i[3:0].
  - m=slope*5-45; n=(offset<<3)-16 (signed).
  - pre=Clip3(1,126,((m*Clip3(0,51,qp))>>>4)+n). The product is 13-bit signed; the shift is arithmetic.
  - valMps=(pre>63).
  - pStateIdx = valMps ? pre-64 : 63-pre.
- Initialisation timing: start_i at cycle t gives writes in t+1..t+64, init_done_o and ctx_rdy_o at t+65.
- READY pipeline, two stages:
  - S0: when ctx_req_i&&ctx_rdy_o, drive rf_r_en_o=1, rf_r_addr_o=ctx_idx_i, and register idx and bin.
  - S1, next cycle: ctx_vld_o=1; state comes from rf_r_data_i or the bypass.
  - S1 update on bin==valMps: pState=min(pState+1,62).
  - S1 update otherwise: if pState==0, toggle valMps; then pState=transIdxLps[pState].
  - S1 writes the updated word the same cycle: rf_w_en_o=1, rf_w_addr_o=idx.
- Throughput: one request per cycle; latency one cycle.
- Hazard: if the S0 index equals the S1 index in the same cycle (back-to-back same context), S1 of the second request uses the forwarded updated word, not RF data. A gap of one or more cycles needs no bypass.
- Requests with ctx_rdy_o=0 are ignored, with no RF access.
- start_i while S1 is active: the S1 write completes; INIT begins next cycle and ctx_rdy_o drops the same cycle as start_i.

Optional Feature:
- Macro CABAC_CTX_STAT_EN.
- Defined: adds outputs bin_cnt_o[15:0] and lps_cnt_o[15:0].
  - Saturating counters of S1 updates and of LPS updates.
  - Cleared on start_i and reset.
- Undefined: ports and logic absent.

Decomposition:
- Package cabac_ctx_pkg holds:
  - CTX_W and CTX_AW;
  - the 64-entry transIdxLps table (6-bit);
  - the ctx word field offsets;
  - the FSM state encoding.
- Sub-module cabac_ctx_init_calc, combinational: (init_val, qp) -> 7-bit word.

Test Plan:
- Init, case 1: init_val=154, qp=26 -> m=0, n=64, pre=64 -> word {0,1}; init_done_o at t+65.
- Init, case 2: init_val=139, qp=26 -> m=-5, product -130>>>4=-9, pre=63 -> word {0,0}.
- MPS then LPS from state {pState=0, mps=1}:
  - bin=1 -> ctx_pstate_o=0, write {1,1};
  - then bin=0 -> pState=transIdxLps[1]=0, mps stays 1.
- LPS at pState=0: state {0,1}, bin=0 -> write {0,0} (MPS flip).
- Back-to-back same index:
  - three consecutive MPS requests on ctx 5 from {10,0} -> outputs pState 10,11,12; final RF {13,0}.
  - identical results with one-cycle gaps.
- Gating and restart:
  - requests during INIT are ignored, with no rf_r_en_o.
  - start_i mid-READY restarts INIT: 64 writes, then rdy.
  - saturation at pState 62 holds at 62.
